bin2bcd_disp: RTL and testbench

//  Sequential double-dabble converter feeding the 3-digit 7-seg display driver.

---
 rtl/bin2bcd_disp.sv | 98 +++++++++
 tb/tb_bin2bcd_disp.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_disp.sv
// Sequential double-dabble converter: saturates a binary count to MAX_VAL and
// produces three packed BCD digits for the 3-digit 7-segment display driver.
module bin2bcd_disp #(
  parameter int BIN_W   = 10,
  parameter int MAX_VAL = 999
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_ovf,
  output logic [23:0]      o_data
);

  localparam int               CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [BIN_W-1:0]    v;
  logic [11:0]         bcd;
  logic [11:0]         bcd_adj;
  logic [11+BIN_W:0]   sh;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pend;

  function automatic logic [BIN_W-1:0] sat_val(input logic [BIN_W-1:0] x);
    return (x > MAX_V) ? MAX_V : x;
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Add-3 correction on every digit, then one left shift of the combined register.
  always_comb begin
    bcd_adj = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
    sh      = {bcd_adj, v} << 1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v        <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_ovf    <= 1'b0;
      o_data   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            v        <= sat_val(i_value);
            ovf_pend <= (i_value > MAX_V);
            bcd      <= '0;
            cnt      <= CNT_W'(BIN_W);
            o_busy   <= 1'b1;
          end
        end
        SHIFT: begin
          bcd <= sh[11+BIN_W:BIN_W];
          v   <= sh[BIN_W-1:0];
          cnt <= cnt - CNT_W'(1);
        end
        DONE: begin
          // Outputs only change here, so the display never sees partial results.
          o_data  <= {12'h000, bcd};
          o_ovf   <= ovf_pend;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Directed-vector bench for bin2bcd_disp with hand-computed BCD results.
module tb_bin2bcd_disp;

  localparam int BIN_W = 10;

  logic             clk;
  logic             rst_n;
  logic [BIN_W-1:0] value;
  logic             start;
  logic             busy;
  logic             valid;
  logic             ovf;
  logic [23:0]      data;

  int n_cmp = 0;
  int n_err = 0;

  bin2bcd_disp #(.BIN_W(BIN_W), .MAX_VAL(999)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_value (value),
    .i_start (start),
    .o_busy  (busy),
    .o_valid (valid),
    .o_ovf   (ovf),
    .o_data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Pulse i_start for one clock; returns #1 after the accepting edge.
  task automatic pulse_start(input logic [BIN_W-1:0] val);
    @(negedge clk);
    value = val;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = '0;
  endtask

  // Counts edges until o_valid; flags any o_data change or busy drop before it.
  task automatic wait_valid(input string tag, output int lat);
    logic [23:0] held;
    bit          bad_hold;
    bit          bad_busy;
    held     = data;
    bad_hold = 0;
    bad_busy = 0;
    lat      = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
      if (data !== held) bad_hold = 1;
      if (busy !== 1'b1) bad_busy = 1;
    end
    chk({tag, "_hold"}, 32'(bad_hold), 32'd0);
    chk({tag, "_busy"}, 32'(bad_busy), 32'd0);
  endtask

  task automatic run_conv(input string tag, input logic [BIN_W-1:0] val,
                          input logic [23:0] exp_data, input logic exp_ovf);
    int lat;
    pulse_start(val);
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_valid(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd11);
    chk({tag, "_data"}, 32'(data), 32'(exp_data));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (valid) cnt++;
    end
  endtask

  initial begin
    int lat;
    int nv;
    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv("v123", 10'd123, 24'h000123, 1'b0);
    run_conv("v0", 10'd0, 24'h000000, 1'b0);
    run_conv("v9", 10'd9, 24'h000009, 1'b0);
    run_conv("v999", 10'd999, 24'h000999, 1'b0);
    run_conv("v1023", 10'd1023, 24'h000999, 1'b1);
    run_conv("v1000", 10'd1000, 24'h000999, 1'b1);
    run_conv("v600", 10'd600, 24'h000600, 1'b0);

    // Start while busy is ignored.
    pulse_start(10'd456);
    repeat (2) @(posedge clk);
    @(negedge clk);
    value = 10'd789;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid("busy_ign", lat);
    chk("busy_ign_lat", 32'(lat), 32'd8);
    chk("busy_ign_data", 32'(data), 32'h000456);

    // Start during the o_valid cycle is accepted.
    value = 10'd321;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = '0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_valid("b2b", lat);
    chk("b2b_lat", 32'(lat), 32'd11);
    chk("b2b_data", 32'(data), 32'h000321);
    count_valid(15, nv);
    chk("busy_ign_single", 32'(nv), 32'd0);

    // Reset mid-conversion abandons it.
    pulse_start(10'd555);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(20, nv);
    chk("mid_rst_novalid", 32'(nv), 32'd0);
    chk("mid_rst_hold", 32'(data), 32'h0);
    run_conv("v42", 10'd42, 24'h000042, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
